audio_mixer_n: RTL

Parametrised audio conditioner for the PC-8001 core's sound outputs. It takes NCH unsigned narrow sources (beeper, future PCG/PSG voices) and applies per-channel mute and volume to each. It sums the channels serially, saturates the result, and passes it through an optional one-pole low-pass filter. The output is a full-width sample in either unsigned or two's-complement format. It sits between the pc8001m core and the AUDIO_L/AUDIO_R outputs, and replaces direct zero-extension of the 4-bit audio.

---
 rtl/audio_mixer_n.sv | 129 ++++++++++++
 1 files changed

// File: rtl/audio_mixer_n.sv
// audio_mixer_n: mute/volume per channel, serial sum, saturate, one-pole LPF.
// One sample takes NCH+3 clocks from strobe to ready-for-next.
module audio_mixer_n #(
  parameter int NCH       = 2,
  parameter int IN_W      = 4,
  parameter int OUT_W     = 16,
  parameter int LPF_SHIFT = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce_sample,
  input  logic [NCH*IN_W-1:0]   ch_in,
  input  logic [NCH-1:0]        ch_mute,
  input  logic [NCH*2-1:0]      vol,
  input  logic                  signed_mode,
  output logic [OUT_W-1:0]      audio_out,
  output logic                  out_valid,
  output logic                  clip,
  output logic                  overrun
);

  localparam int SW = OUT_W + $clog2(NCH) + 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = OUT_W + LPF_SHIFT;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic [OUT_W-1:0] MSB = OUT_W'(1) << (OUT_W - 1);

  typedef enum logic [1:0] {IDLE, ACC, SAT, FILT} state_t;

  state_t                r_state;
  logic [NCH*IN_W-1:0]   r_ch;
  logic [NCH-1:0]        r_mute;
  logic [NCH*2-1:0]      r_vol;
  logic                  r_sgn;
  logic [IW-1:0]         r_idx;
  logic [SW-1:0]         r_sum;
  logic [OUT_W-1:0]      r_sat;
  logic                  r_clip;
  logic [AW-1:0]         r_acc;

  logic [IN_W-1:0]       w_ch;
  logic                  w_mute;
  logic [1:0]            w_vol;
  logic [OUT_W-1:0]      w_ext;
  logic [OUT_W-1:0]      w_scaled;
  logic                  w_ovf;
  logic [OUT_W-1:0]      w_sat;
  logic [AW-1:0]         w_acc_nx;
  logic [OUT_W-1:0]      w_y;
  logic [OUT_W-1:0]      w_out;

  always_comb begin
    w_ch   = '0;
    w_mute = 1'b0;
    w_vol  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_idx == IW'(i)) begin
        w_ch   = r_ch[i*IN_W +: IN_W];
        w_mute = r_mute[i];
        w_vol  = r_vol[i*2 +: 2];
      end
    end
  end

  // Left-justify the narrow sample so vol=3 is full scale.
  assign w_ext    = OUT_W'(w_ch) << (OUT_W - IN_W);
  assign w_scaled = w_mute ? '0 : (w_ext >> (2'd3 - w_vol));
  assign w_ovf    = |r_sum[SW-1:OUT_W];
  assign w_sat    = w_ovf ? '1 : r_sum[OUT_W-1:0];

  // With LPF_SHIFT=0 this reduces exactly to y = sat.
  assign w_acc_nx = r_acc + AW'(r_sat) - (r_acc >> LPF_SHIFT);
  assign w_y      = w_acc_nx[LPF_SHIFT +: OUT_W];
  assign w_out    = r_sgn ? (w_y ^ MSB) : w_y;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_mute    <= '0;
      r_vol     <= '0;
      r_sgn     <= 1'b0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_sat     <= '0;
      r_clip    <= 1'b0;
      r_acc     <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= ce_sample && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (ce_sample) begin
            r_ch    <= ch_in;
            r_mute  <= ch_mute;
            r_vol   <= vol;
            r_sgn   <= signed_mode;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= ACC;
          end
        end
        ACC: begin
          r_sum <= r_sum + SW'(w_scaled);
          if (r_idx == LAST) r_state <= SAT;
          else               r_idx   <= r_idx + 1'b1;
        end
        SAT: begin
          r_sat   <= w_sat;
          r_clip  <= w_ovf;
          r_state <= FILT;
        end
        FILT: begin
          r_acc     <= w_acc_nx;
          audio_out <= w_out;
          out_valid <= 1'b1;
          clip      <= r_clip;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
